// File: rtl/mac_vec.sv
// Multi-lane dot-product MAC: LANES operand pairs per beat, LEN beats per result.
// Two-stage pipeline (lane multiply, adder tree + saturating accumulate) with valid/ready handshakes.
module mac_vec #(
    parameter int DATA_W = 8,
    parameter int LANES  = 4,
    parameter int ACC_W  = 20,
    parameter int CNT_W  = 8
) (
    input  logic                      clk,
    input  logic                      r,
    input  logic                      start,
    input  logic [CNT_W-1:0]          len,
    input  logic                      signed_md,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*DATA_W-1:0]   a,
    input  logic [LANES*DATA_W-1:0]   b,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ACC_W-1:0]          acc,
    output logic                      of,
    output logic                      busy
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int SUM_W  = 2 * DATA_W + $clog2(LANES) + 1;
    localparam int EXT_W  = (SUM_W + 1 > ACC_W + 2) ? SUM_W + 1 : ACC_W + 2;

    localparam logic signed [EXT_W-1:0] UMAX_X = EXT_W'({ACC_W{1'b1}});
    localparam logic signed [EXT_W-1:0] SMAX_X = EXT_W'({1'b0, {(ACC_W-1){1'b1}}});
    localparam logic signed [EXT_W-1:0] SMIN_X = -SMAX_X - EXT_W'(1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t                    state;
    logic [CNT_W-1:0]          remaining;
    logic                      md_q;
    logic                      accept;

    logic signed [PROD_W-1:0]  prod_p0 [LANES];
    logic signed [PROD_W-1:0]  prod_p1 [LANES];
    logic                      vld_p1;
    logic signed [SUM_W-1:0]   sum_p1;
    logic signed [EXT_W-1:0]   tot_p1;
    logic [ACC_W:0]            sat_p1;

    // Operands are extended per mode to the product width; the true product always fits there.
    function automatic logic signed [PROD_W-1:0] mul_lane(input logic [DATA_W-1:0] x,
                                                          input logic [DATA_W-1:0] y,
                                                          input logic md);
        logic signed [PROD_W-1:0] xe;
        logic signed [PROD_W-1:0] ye;
        xe = {{DATA_W{md & x[DATA_W-1]}}, x};
        ye = {{DATA_W{md & y[DATA_W-1]}}, y};
        return xe * ye;
    endfunction

    function automatic logic signed [SUM_W-1:0] ext_prod(input logic signed [PROD_W-1:0] p,
                                                         input logic md);
        return {{(SUM_W-PROD_W){md & p[PROD_W-1]}}, p};
    endfunction

    // Returns {clamped, value}.
    function automatic logic [ACC_W:0] sat_acc(input logic signed [EXT_W-1:0] x,
                                               input logic md);
        if (!md) begin
            if (x > UMAX_X) return {1'b1, {ACC_W{1'b1}}};
        end else begin
            if (x > SMAX_X) return {1'b1, 1'b0, {(ACC_W-1){1'b1}}};
            if (x < SMIN_X) return {1'b1, 1'b1, {(ACC_W-1){1'b0}}};
        end
        return {1'b0, x[ACC_W-1:0]};
    endfunction

    assign in_ready  = (state == RUN);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign accept    = in_valid & in_ready;

    // Stage 0 -> 1: lane products
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            prod_p0[i] = mul_lane(a[i*DATA_W +: DATA_W], b[i*DATA_W +: DATA_W], md_q);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < LANES; i++) prod_p1[i] <= prod_p0[i];
        end
    end

    // Stage 1 -> 2: adder tree, accumulate, saturate
    always_comb begin
        sum_p1 = '0;
        for (int i = 0; i < LANES; i++) sum_p1 = sum_p1 + ext_prod(prod_p1[i], md_q);
        tot_p1 = $signed({{(EXT_W-ACC_W){md_q & acc[ACC_W-1]}}, acc}) + EXT_W'(sum_p1);
        sat_p1 = sat_acc(tot_p1, md_q);
    end

    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            state     <= IDLE;
            remaining <= '0;
            md_q      <= 1'b0;
            vld_p1    <= 1'b0;
            acc       <= '0;
            of        <= 1'b0;
        end else begin
            vld_p1 <= accept;
            if (vld_p1) begin
                acc <= sat_p1[ACC_W-1:0];
                if (sat_p1[ACC_W]) of <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        remaining <= len;
                        md_q      <= signed_md;
                        acc       <= '0;
                        of        <= 1'b0;
                        state     <= (len == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        remaining <= remaining - 1'b1;
                        if (remaining == CNT_W'(1)) state <= FLUSH;
                    end
                end
                FLUSH: state <= DONE;
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
